// File: rtl/div_pkg.sv
// Purpose: shared widths, constants and FSM state encoding for the 8/4 divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   DIVIDEND_W / DIVISOR_W  operand widths (quotient = dividend width,
//                           remainder = divisor width)
//   REM5_W                  internal partial-remainder width (one guard bit)
//   div_state_e             IDLE -> CALC -> DONE control FSM
package div_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int QUOT_W     = DIVIDEND_W;
  localparam int REM_W      = DIVISOR_W;
  localparam int REM5_W     = DIVISOR_W + 1;
  localparam int CNT_W      = 3;

  // One iteration per dividend bit; the counter walks 7 down to 0.
  localparam logic [CNT_W-1:0]  ITER_LOAD = 3'd7;

  // Result reported for a zero divisor: all-ones quotient, zero remainder.
  localparam logic [QUOT_W-1:0] DZ_QUOT = 8'hFF;
  localparam logic [REM_W-1:0]  DZ_REM  = 4'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// Purpose: one restoring-division step (shift in a dividend bit, try-subtract).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
//
// Ports:
//   rem4_i       partial remainder from the previous step (always < b_i)
//   dbit_i       next dividend bit, MSB first
//   b_i          divisor
//   rem4_next_o  partial remainder after this step
//   qbit_o       quotient bit produced by this step
module div_step
  import div_pkg::*;
(
  input  logic [REM_W-1:0] rem4_i,
  input  logic             dbit_i,
  input  logic [REM_W-1:0] b_i,
  output logic [REM_W-1:0] rem4_next_o,
  output logic             qbit_o
);

  logic [REM5_W-1:0] rem5;
  logic [REM_W-1:0]  diff4;
  logic              ge;

  assign rem5 = {rem4_i, dbit_i};
  assign ge   = (rem5 >= {1'b0, b_i});

  // When the subtraction is taken the true difference is < b <= 15, so the
  // low four bits of (rem5 - b) are exact and the modulo-16 subtract on the
  // low nibble gives the same answer without carrying the guard bit around.
  assign diff4 = rem5[REM_W-1:0] - b_i;

  always_comb begin
    qbit_o      = 1'b0;
    rem4_next_o = rem5[REM_W-1:0];
    if (ge) begin
      qbit_o      = 1'b1;
      rem4_next_o = diff4;
    end
  end

endmodule

// File: rtl/div_8x4_seq.sv
// Purpose: sequential unsigned 8-bit / 4-bit restoring divider with divide-by-zero flag.
// Latency: 8 cycles accept-to-done (1 cycle for b==0); 9-cycle back-to-back throughput.
// Backpressure: start is ignored while busy; a new start is taken in IDLE or in the DONE cycle.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request pulse, sampled on rising clk
//   a, b         dividend / divisor, captured only when start is accepted
//   q, r         quotient / remainder, registered, held until the next result
//   busy         high during the eight CALC cycles
//   done         one-cycle pulse when q/r/dz are updated
//   dz           divide-by-zero flag belonging to the current q/r
module div_8x4_seq
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] a,
  input  logic [DIVISOR_W-1:0]  b,
  output logic [QUOT_W-1:0]     q,
  output logic [REM_W-1:0]      r,
  output logic                  busy,
  output logic                  done,
  output logic                  dz
);

  // Control and working registers.
  div_state_e            state_q;
  logic [DIVIDEND_W-1:0] dvd_q;   // dividend, shifted left one bit per step
  logic [DIVISOR_W-1:0]  dvs_q;   // latched divisor
  logic [REM_W-1:0]      rem_q;   // partial remainder
  logic [QUOT_W-1:0]     quo_q;   // working quotient, hidden until DONE
  logic [CNT_W-1:0]      cnt_q;   // remaining iterations minus one

  // Registered outputs.
  logic [QUOT_W-1:0]     q_q;
  logic [REM_W-1:0]      r_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  dz_q;

  // Next-step values from the shared restoring step.
  logic [REM_W-1:0]      rem_d;
  logic                  qbit_d;
  logic [QUOT_W-1:0]     quo_d;

  div_step u_step (
    .rem4_i      (rem_q),
    .dbit_i      (dvd_q[DIVIDEND_W-1]),
    .b_i         (dvs_q),
    .rem4_next_o (rem_d),
    .qbit_o      (qbit_d)
  );

  assign quo_d = {quo_q[QUOT_W-2:0], qbit_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        // IDLE and DONE share acceptance logic: a start in the DONE cycle
        // is taken on the same edge that would otherwise return to IDLE.
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            if (b == '0) begin
              // Zero divisor: no iterations, result is ready right away.
              state_q <= ST_DONE;
              q_q     <= DZ_QUOT;
              r_q     <= DZ_REM;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              // q/r keep the previous result until this division ends.
              state_q <= ST_CALC;
              dvd_q   <= a;
              dvs_q   <= b;
              rem_q   <= '0;
              quo_q   <= '0;
              cnt_q   <= ITER_LOAD;
              dz_q    <= 1'b0;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end

        // start is deliberately not looked at here.
        ST_CALC: begin
          dvd_q <= {dvd_q[DIVIDEND_W-2:0], 1'b0};
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            // Last bit: publish the full quotient including this step's bit.
            state_q <= ST_DONE;
            q_q     <= quo_d;
            r_q     <= rem_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_div_8x4_seq.sv
// Purpose: self-checking bench for div_8x4_seq using an expected-result queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_div_8x4_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [3:0] b;
  logic [7:0] q;
  logic [3:0] r;
  logic       busy;
  logic       done;
  logic       dz;

  div_8x4_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .dz    (dz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("q", {24'd0, q}, {24'd0, mon_e.q});
        chk("r", {28'd0, r}, {28'd0, mon_e.r});
        chk("dz", {31'd0, dz}, {31'd0, mon_e.dz});
        chk("done_cycle", cyc, mon_e.cyc);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        if (mon_e.b != 0) begin
          chk("inv_qb_plus_r", 32'(q) * 32'(mon_e.b) + 32'(r), 32'(mon_e.a));
          chk("inv_r_lt_b", {31'd0, (r < mon_e.b)}, 32'd1);
        end
      end
    end
  end

  // Drive one request after `gap` falling edges; it is sampled on the next rising edge.
  task automatic issue(input logic [7:0] av, input logic [3:0] bv, input int gap, input bit track);
    exp_t e;
    repeat (gap) @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (track) begin
      e.a   = av;
      e.b   = bv;
      e.q   = (bv == 0) ? 8'hFF : av / bv;
      e.r   = (bv == 0) ? 4'h0  : 4'(av % bv);
      e.dz  = (bv == 0);
      e.cyc = (bv == 0) ? cyc : cyc + 8;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  int perm[4096];
  int tmp;
  int j;
  int gap;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #3;
    chk("rst_q", {24'd0, q}, 32'd0);
    chk("rst_r", {28'd0, r}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dz", {31'd0, dz}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 200 / 7: busy for exactly eight cycles, q/r untouched meanwhile.
    issue(8'd200, 4'd7, 1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("calc_busy", {31'd0, busy}, 32'd1);
      chk("calc_q_hold", {24'd0, q}, 32'd0);
      chk("calc_done_low", {31'd0, done}, 32'd0);
      @(posedge clk);
      #1;
    end
    drain(20);
    repeat (3) @(negedge clk);
    chk("hold_q", {24'd0, q}, 32'd28);
    chk("hold_r", {28'd0, r}, 32'd4);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    issue(8'd255, 4'd15, 1, 1'b1);
    drain(20);
    issue(8'd5, 4'd9, 1, 1'b1);
    drain(20);
    issue(8'd0, 4'd1, 1, 1'b1);
    drain(20);

    // Zero divisor, then a normal division started in the DONE cycle.
    issue(8'd100, 4'd0, 1, 1'b1);
    issue(8'd9, 4'd2, 1, 1'b1);
    drain(20);

    // A start during CALC must be ignored.
    issue(8'd200, 4'd7, 1, 1'b1);
    issue(8'd1, 4'd1, 3, 1'b0);
    drain(20);
    repeat (4) @(negedge clk);

    // Reset in the middle of CALC: outputs clear at once, no done afterwards.
    issue(8'd123, 4'd5, 1, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_q", {24'd0, q}, 32'd0);
    chk("abort_r", {28'd0, r}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_dz", {31'd0, dz}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_busy", {31'd0, busy}, 32'd0);
    issue(8'd50, 4'd6, 1, 1'b1);
    drain(20);

    // All 4096 operand pairs in shuffled order, each start placed in the DONE cycle.
    for (int i = 0; i < 4096; i++) perm[i] = i;
    for (int i = 4095; i > 0; i--) begin
      j       = int'($urandom_range(i, 0));
      tmp     = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    gap = 1;
    for (int k = 0; k < 4096; k++) begin
      issue(8'(perm[k] >> 4), 4'(perm[k]), gap, 1'b1);
      gap = ((perm[k] & 15) == 0) ? 1 : 9;
    end
    drain(40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
